// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write-only slave: captures one AW/W pair, issues a single-cycle
// write pulse downstream, then returns a B response (SLVERR when out of range).
module axi_lite_write_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int ADDR_SPACE     = 547684
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr,
  output logic [31:0]               axi_wr_data,
  output logic [3:0]                axi_wr_strobe,
  output logic                      axi_wr_en
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = AXI_ADDR_WIDTH'(ADDR_SPACE);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(3);

  state_t                      state;
  logic                        aw_captured;
  logic                        w_captured;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_q;
  logic [31:0]                 w_data_q;
  logic [3:0]                  w_strb_q;
  logic                        in_range_q;

  logic                        aw_fire;
  logic                        w_fire;
  logic                        aw_done;
  logic                        w_done;
  logic [AXI_ADDR_WIDTH-1:0]   next_addr;
  logic [31:0]                 next_data;
  logic [3:0]                  next_strb;
  logic                        next_in_range;

  // Merge the live handshake with the holding registers so the second
  // handshake (or both together) can launch the write on that same edge.
  always_comb begin
    aw_fire       = 1'b0;
    w_fire        = 1'b0;
    if (state == IDLE) begin
      aw_fire = s_axi_awvalid & s_axi_awready;
      w_fire  = s_axi_wvalid & s_axi_wready;
    end
    aw_done       = aw_captured | aw_fire;
    w_done        = w_captured | w_fire;
    next_addr     = aw_fire ? (s_axi_awaddr & ALIGN_MASK) : aw_addr_q;
    next_data     = w_fire ? s_axi_wdata : w_data_q;
    next_strb     = w_fire ? s_axi_wstrb : w_strb_q;
    next_in_range = (next_addr < ADDR_LIMIT);
  end

  // NOTE: every register here uses <=, so all reads in this block see the
  // pre-edge values; this is what keeps the single-block FSM race-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      aw_captured   <= 1'b0;
      w_captured    <= 1'b0;
      // NOTE: the holding registers are reset too; they are only a few
      // flops and it keeps the outputs deterministic after reset.
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      in_range_q    <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      axi_wr_addr   <= '0;
      axi_wr_data   <= '0;
      axi_wr_strobe <= '0;
      axi_wr_en     <= 1'b0;
    end else begin
      axi_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (aw_fire) begin
            aw_addr_q   <= next_addr;
            aw_captured <= 1'b1;
          end
          if (w_fire) begin
            w_data_q   <= next_data;
            w_strb_q   <= next_strb;
            w_captured <= 1'b1;
          end
          if (aw_done && w_done) begin
            state         <= WRITE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            axi_wr_addr   <= next_addr;
            axi_wr_data   <= next_data;
            axi_wr_strobe <= next_strb;
            axi_wr_en     <= next_in_range && (next_strb != 4'b0000);
            in_range_q    <= next_in_range;
          end else begin
            s_axi_awready <= !aw_done;
            s_axi_wready  <= !w_done;
          end
        end

        WRITE: begin
          state        <= RESP;
          s_axi_bvalid <= 1'b1;
          s_axi_bresp  <= in_range_q ? RESP_OKAY : RESP_SLVERR;
        end

        RESP: begin
          // Readies stay low here; IDLE raises them one edge later.
          if (s_axi_bready) begin
            state        <= IDLE;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            aw_captured  <= 1'b0;
            w_captured   <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_lite_write_slave.md
AXI_LITE_WRITE_SLAVE -- requirements
Module: axi_lite_write_slave

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32: width of the AXI write address and of the output address.
REQ-002 SHALL have parameter ADDR_SPACE, default 547684: exclusive upper bound of accepted byte addresses.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_axi_awaddr, input, AXI_ADDR_WIDTH bits: write address.
REQ-006 SHALL have port s_axi_awvalid, input, 1 bit, and port s_axi_awready, output, 1 bit: AW handshake.
REQ-007 SHALL have port s_axi_wdata, input, 32 bits: write data.
REQ-008 SHALL have port s_axi_wstrb, input, 4 bits: byte strobes.
REQ-009 SHALL have port s_axi_wvalid, input, 1 bit, and port s_axi_wready, output, 1 bit: W handshake.
REQ-010 SHALL have port s_axi_bresp, output, 2 bits, port s_axi_bvalid, output, 1 bit, and port s_axi_bready, input, 1 bit: B channel.
REQ-011 SHALL have port axi_wr_addr, output, AXI_ADDR_WIDTH bits: word-aligned byte address, bits [1:0] forced to 0.
REQ-012 SHALL have ports axi_wr_data, output, 32 bits, and axi_wr_strobe, output, 4 bits: captured data and strobes.
REQ-013 SHALL have port axi_wr_en, output, 1 bit: single-cycle write pulse to the downstream write controllers.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE and RESP.
REQ-015 In IDLE, SHALL accept AW and W independently, in either order or in the same cycle; each channel is latched into its own holding register with a captured flag.
REQ-016 s_axi_awready SHALL be a registered output: high in IDLE while AW is not captured, low in the cycle after the AW handshake, low in WRITE/RESP. s_axi_wready SHALL follow the same rule for W.
REQ-017 On the clock edge at which both captured flags become true (the second handshake, or both together), the FSM SHALL go IDLE -> WRITE.
REQ-018 In WRITE, for exactly one cycle, SHALL drive axi_wr_addr = {awaddr[AXI_ADDR_WIDTH-1:2], 2'b00}, axi_wr_data = wdata, axi_wr_strobe = wstrb; then the FSM SHALL go WRITE -> RESP.
REQ-019 In WRITE, axi_wr_en SHALL be 1 iff the aligned address < ADDR_SPACE and wstrb != 4'b0000.
REQ-020 Address comparison SHALL be unsigned at full AXI_ADDR_WIDTH; an address equal to ADDR_SPACE counts as out of range.
REQ-021 In RESP, s_axi_bvalid SHALL be 1; s_axi_bresp SHALL be 2'b00 (OKAY) if in range, otherwise 2'b10 (SLVERR).
REQ-022 A zero-strobe write that is in range SHALL get response OKAY with no wr_en pulse.
REQ-023 s_axi_bvalid and s_axi_bresp SHALL hold stable until s_axi_bready is sampled high; the FSM SHALL then go RESP -> IDLE, clear both captured flags, and raise both readies on the next cycle.
REQ-024 Latency: handshake completion at edge N -> axi_wr_en high in cycle N+1 -> s_axi_bvalid high from cycle N+2.
REQ-025 No new AW or W SHALL be accepted from WRITE entry until the B handshake completes; at most one transaction is outstanding.
REQ-026 axi_wr_en SHALL be 0 in every cycle outside WRITE; axi_wr_addr, axi_wr_data and axi_wr_strobe SHALL hold their last value between pulses.
REQ-027 The back-to-back minimum transaction period SHALL be 4 cycles when bready is held high.

Reset
REQ-028 While rst_n = 0, SHALL force the FSM to IDLE and clear both captured flags.
REQ-029 While rst_n = 0, SHALL drive s_axi_awready, s_axi_wready, s_axi_bvalid and axi_wr_en to 0, s_axi_bresp to 2'b00, and axi_wr_addr, axi_wr_data and axi_wr_strobe to 0.
REQ-030 After rst_n deasserts, both readies SHALL rise at the first clock edge.
REQ-031 A reset asserted mid-transaction, in any state, SHALL discard that transaction: no wr_en pulse and no B response after release.

Verification
REQ-032 AW 0x60204 and W 0x1234ABCD/4'hF in the same cycle, bready = 1 -> one wr_en pulse with addr 0x60204, data 0x1234ABCD, strobe 4'hF; bresp 2'b00 two cycles after the handshake.
REQ-033 W sent 3 cycles before AW (addr 0x60206) -> wready drops after the W handshake; wr_en pulse with addr 0x60204 (aligned) one cycle after the AW handshake.
REQ-034 AW 547684 (= ADDR_SPACE), W 4'hF -> no wr_en pulse; bresp 2'b10. AW 547680 -> wr_en pulses; bresp 2'b00.
REQ-035 bready held 0 for 10 cycles -> bvalid and bresp stable throughout, both readies low, and a second AW/W presented meanwhile is not accepted until after the B handshake.
REQ-036 rst_n pulsed low in WRITE and again in RESP -> all outputs 0 immediately; no pulse or response afterwards; readies high 1 edge after release.
REQ-037 Strobe 4'h0 at addr 0x60208 -> no wr_en pulse; bresp 2'b00.
